phase1_datapath: RTL and testbench

Single-bus CPU datapath slice for phase-1 bring-up.
- Contents: general registers R6/R7, special registers PC, IR, MAR, MDR, Y, HI, LO, a 64-bit Z result register, a 32-bit shared bus, and a 5-bit-opcode ALU.
- All register transfers are driven by external one-hot control strobes from a sequencer or testbench.
- Used to verify multi-cycle instruction sequences such as DIV (R6/R7 → LO/HI).

---
 rtl/phase1_datapath.sv | 170 +++++++++++++++++
 tb/tb_phase1_datapath.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase1_datapath.sv
// Single-bus CPU datapath slice for phase-1 bring-up: register file subset, priority bus,
// 64-bit Z result register and a 5-bit-opcode ALU. All transfers are driven by one-hot control strobes.
module phase1_datapath #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             Clock,
   input  logic             Clear,
   input  logic             R6in,
   input  logic             R7in,
   input  logic             HIin,
   input  logic             LOin,
   input  logic             MARin,
   input  logic             Zin,
   input  logic             PCin,
   input  logic             MDRin,
   input  logic             IRin,
   input  logic             Yin,
   input  logic             R6out,
   input  logic             R7out,
   input  logic             PCout,
   input  logic             ZHIout,
   input  logic             ZLOout,
   input  logic             MDRout,
   input  logic             IncrementPC,
   input  logic             Read,
   input  logic [4:0]       ALUControl,
   input  logic [WIDTH-1:0] Mdatain,
   output logic [WIDTH-1:0] R6_data_out,
   output logic [WIDTH-1:0] R7_data_out,
   output logic [WIDTH-1:0] big_boy_bus,
   output logic [WIDTH-1:0] MDR_data_in,
   output logic [WIDTH-1:0] MDR_data_out,
   output logic [WIDTH-1:0] Y_data_out,
   output logic [WIDTH-1:0] Z_data_out,
   output logic [WIDTH-1:0] HI_data_out,
   output logic [WIDTH-1:0] LO_data_out
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned ZW  = 2 * WIDTH;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_MUL  = 5'd2;
   localparam logic [4:0] OP_DIV  = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_OR   = 5'd5;
   localparam logic [4:0] OP_SHR  = 5'd6;
   localparam logic [4:0] OP_SHRA = 5'd7;
   localparam logic [4:0] OP_SHL  = 5'd8;
   localparam logic [4:0] OP_ROR  = 5'd9;
   localparam logic [4:0] OP_ROL  = 5'd10;
   localparam logic [4:0] OP_NEG  = 5'd11;
   localparam logic [4:0] OP_NOT  = 5'd12;

   logic [WIDTH-1:0] r6_q, r7_q, pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
   logic [ZW-1:0]    z_q;

   logic [WIDTH-1:0] bus_c;
   logic [WIDTH-1:0] mdr_d_c;
   logic [ZW-1:0]    alu_c;

   // Priority bus mux; control is expected to keep the selects one-hot
   always_comb begin
      bus_c = '0;
      if (MDRout)      bus_c = mdr_q;
      else if (PCout)  bus_c = pc_q;
      else if (ZHIout) bus_c = z_q[ZW-1:WIDTH];
      else if (ZLOout) bus_c = z_q[WIDTH-1:0];
      else if (R6out)  bus_c = r6_q;
      else if (R7out)  bus_c = r7_q;
   end

   assign mdr_d_c = Read ? Mdatain : bus_c;

   // ALU operand views: A = Y, B = bus
   logic signed [WIDTH-1:0] a_s, b_s;
   logic        [SHW-1:0]   shamt;
   logic signed [ZW-1:0]    prod;
   logic        [ZW-1:0]    dbl, rot_r, rot_l;

   assign a_s   = y_q;
   assign b_s   = bus_c;
   assign shamt = bus_c[SHW-1:0];
   assign prod  = ZW'(a_s) * ZW'(b_s);
   assign dbl   = {y_q, y_q};
   assign rot_r = dbl >> shamt;
   assign rot_l = dbl << shamt;

   // Signed divide on magnitudes so -2^31 / -1 wraps to 0x80000000 without a trap
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

   assign a_neg = y_q[WIDTH-1];
   assign b_neg = bus_c[WIDTH-1];
   assign a_mag = a_neg ? (~y_q + WIDTH'(1)) : y_q;
   assign b_mag = b_neg ? (~bus_c + WIDTH'(1)) : bus_c;

   always_comb begin
      q_mag = '0;
      r_mag = '0;
      quot  = '1;
      rem   = y_q;
      if (bus_c != '0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
         quot  = (a_neg ^ b_neg) ? (~q_mag + WIDTH'(1)) : q_mag;
         rem   = a_neg ? (~r_mag + WIDTH'(1)) : r_mag;
      end
   end

   always_comb begin
      alu_c = '0;
      unique case (ALUControl)
         OP_ADD:  alu_c = {{WIDTH{1'b0}}, y_q + bus_c};
         OP_SUB:  alu_c = {{WIDTH{1'b0}}, y_q - bus_c};
         OP_MUL:  alu_c = prod;
         OP_DIV:  alu_c = {rem, quot};
         OP_AND:  alu_c = {{WIDTH{1'b0}}, y_q & bus_c};
         OP_OR:   alu_c = {{WIDTH{1'b0}}, y_q | bus_c};
         OP_SHR:  alu_c = {{WIDTH{1'b0}}, y_q >> shamt};
         OP_SHRA: alu_c = {{WIDTH{1'b0}}, WIDTH'(a_s >>> shamt)};
         OP_SHL:  alu_c = {{WIDTH{1'b0}}, y_q << shamt};
         OP_ROR:  alu_c = {{WIDTH{1'b0}}, rot_r[WIDTH-1:0]};
         OP_ROL:  alu_c = {{WIDTH{1'b0}}, rot_l[ZW-1:WIDTH]};
         OP_NEG:  alu_c = {{WIDTH{1'b0}}, WIDTH'(0) - bus_c};
         OP_NOT:  alu_c = {{WIDTH{1'b0}}, ~bus_c};
         default: alu_c = '0;
      endcase
   end

   // Register file; Clear overrides every load enable
   always_ff @(posedge Clock) begin
      if (!Clear) begin
         r6_q  <= '0;
         r7_q  <= '0;
         pc_q  <= PC_RESET;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         y_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         z_q   <= '0;
      end else begin
         if (R6in)  r6_q  <= bus_c;
         if (R7in)  r7_q  <= bus_c;
         if (IRin)  ir_q  <= bus_c;
         if (MARin) mar_q <= bus_c;
         if (Yin)   y_q   <= bus_c;
         if (HIin)  hi_q  <= bus_c;
         if (LOin)  lo_q  <= bus_c;
         if (MDRin) mdr_q <= mdr_d_c;
         if (Zin)   z_q   <= alu_c;
         if (PCin)  pc_q  <= IncrementPC ? (pc_q + WIDTH'(1)) : bus_c;
      end
   end

   assign R6_data_out  = r6_q;
   assign R7_data_out  = r7_q;
   assign big_boy_bus  = bus_c;
   assign MDR_data_in  = mdr_d_c;
   assign MDR_data_out = mdr_q;
   assign Y_data_out   = y_q;
   assign Z_data_out   = z_q[WIDTH-1:0];
   assign HI_data_out  = hi_q;
   assign LO_data_out  = lo_q;

endmodule

// File: tb/tb_phase1_datapath.sv
// Scoreboard bench for phase1_datapath: directed bring-up sequences plus randomized ALU ops
// checked against a plain-arithmetic reference model.
module tb_phase1_datapath;

   logic        Clock = 1'b0;
   logic        Clear;
   logic        R6in, R7in, HIin, LOin, MARin, Zin, PCin, MDRin, IRin, Yin;
   logic        R6out, R7out, PCout, ZHIout, ZLOout, MDRout;
   logic        IncrementPC, Read;
   logic [4:0]  ALUControl;
   logic [31:0] Mdatain;
   logic [31:0] R6_data_out, R7_data_out, big_boy_bus, MDR_data_in, MDR_data_out;
   logic [31:0] Y_data_out, Z_data_out, HI_data_out, LO_data_out;

   always #5 Clock = ~Clock;

   phase1_datapath #(.WIDTH(32), .PC_RESET(32'h0)) dut (
      .Clock(Clock), .Clear(Clear),
      .R6in(R6in), .R7in(R7in), .HIin(HIin), .LOin(LOin), .MARin(MARin), .Zin(Zin),
      .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .R6out(R6out), .R7out(R7out), .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout),
      .MDRout(MDRout), .IncrementPC(IncrementPC), .Read(Read), .ALUControl(ALUControl),
      .Mdatain(Mdatain),
      .R6_data_out(R6_data_out), .R7_data_out(R7_data_out), .big_boy_bus(big_boy_bus),
      .MDR_data_in(MDR_data_in), .MDR_data_out(MDR_data_out), .Y_data_out(Y_data_out),
      .Z_data_out(Z_data_out), .HI_data_out(HI_data_out), .LO_data_out(LO_data_out)
   );

   localparam int O_R6 = 0, O_R7 = 1, O_BUS = 2, O_MDRIN = 3, O_MDR = 4, O_Y = 5;
   localparam int O_Z = 6, O_HI = 7, O_LO = 8, O_PC = 9, O_IR = 10, O_MAR = 11;

   int          idq[$];
   logic [31:0] expq[$];
   string       nameq[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   function automatic logic [31:0] observe(int id);
      case (id)
         O_R6:    return R6_data_out;
         O_R7:    return R7_data_out;
         O_BUS:   return big_boy_bus;
         O_MDRIN: return MDR_data_in;
         O_MDR:   return MDR_data_out;
         O_Y:     return Y_data_out;
         O_Z:     return Z_data_out;
         O_HI:    return HI_data_out;
         O_LO:    return LO_data_out;
         O_PC:    return dut.pc_q;
         O_IR:    return dut.ir_q;
         default: return dut.mar_q;
      endcase
   endfunction

   // Monitor: drains the scoreboard on every falling edge, away from register updates
   always @(negedge Clock) begin
      while (idq.size() > 0) begin
         automatic int          id  = idq.pop_front();
         automatic logic [31:0] ex  = expq.pop_front();
         automatic string       nm  = nameq.pop_front();
         automatic logic [31:0] act = observe(id);
         n_tests++;
         if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, ex);
         end
      end
   end

   task automatic expect_val(input int id, input logic [31:0] ex, input string nm);
      idq.push_back(id);
      expq.push_back(ex);
      nameq.push_back(nm);
   endtask

   task automatic idle();
      {R6in, R7in, HIin, LOin, MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
      {R6out, R7out, PCout, ZHIout, ZLOout, MDRout} = '0;
      IncrementPC = 1'b0;
      Read        = 1'b0;
      ALUControl  = 5'd0;
   endtask

   // One transfer: strobes already set, take the edge, then drop them
   task automatic step();
      @(posedge Clock);
      #1;
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Mdatain = v; Read = 1'b1; MDRin = 1'b1;
      step();
   endtask

   // Reference ALU from the instruction-set rules, using wide signed arithmetic and bit loops
   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa = longint'(int'(a));
      longint      sb = longint'(int'(b));
      logic [31:0] t;
      int          n  = int'(b[4:0]);
      case (op)
         5'd0:  return {32'h0, 32'(sa + sb)};
         5'd1:  return {32'h0, 32'(sa - sb)};
         5'd2:  return 64'(sa * sb);
         5'd3: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         5'd4:  return {32'h0, a & b};
         5'd5:  return {32'h0, a | b};
         5'd6:  begin t = a; for (int i = 0; i < n; i++) t = {1'b0, t[31:1]};  return {32'h0, t}; end
         5'd7:  begin t = a; for (int i = 0; i < n; i++) t = {t[31], t[31:1]}; return {32'h0, t}; end
         5'd8:  begin t = a; for (int i = 0; i < n; i++) t = {t[30:0], 1'b0};  return {32'h0, t}; end
         5'd9:  begin t = a; for (int i = 0; i < n; i++) t = {t[0], t[31:1]};  return {32'h0, t}; end
         5'd10: begin t = a; for (int i = 0; i < n; i++) t = {t[30:0], t[31]}; return {32'h0, t}; end
         5'd11: return {32'h0, 32'(-sb)};
         5'd12: return {32'h0, ~b};
         default: return 64'h0;
      endcase
   endfunction

   // Y <= a, Z <= a op b, then LO <= Z low, HI <= Z high
   task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input string nm);
      logic [63:0] ex;
      ex = ref_alu(op, a, b);
      load_mdr(a);
      MDRout = 1'b1; Yin = 1'b1;
      step();
      expect_val(O_Y, a, {nm, "_y"});
      load_mdr(b);
      MDRout = 1'b1; ALUControl = op; Zin = 1'b1;
      step();
      expect_val(O_Z, ex[31:0], {nm, "_z"});
      ZLOout = 1'b1; LOin = 1'b1;
      step();
      expect_val(O_LO, ex[31:0], {nm, "_lo"});
      ZHIout = 1'b1; HIin = 1'b1;
      step();
      expect_val(O_HI, ex[63:32], {nm, "_hi"});
   endtask

   initial begin
      idle();
      Mdatain = 32'hDEAD_BEEF;
      Clear   = 1'b0;
      // Reset with every load strobe high: Clear must win
      {R6in, R7in, HIin, LOin, MARin, Zin, PCin, MDRin, IRin, Yin} = '1;
      MDRout = 1'b1; Read = 1'b1;
      @(posedge Clock);
      #1;
      Clear = 1'b1;
      idle();
      expect_val(O_R6, 32'h0, "rst_r6");   expect_val(O_R7, 32'h0, "rst_r7");
      expect_val(O_MDR, 32'h0, "rst_mdr"); expect_val(O_Y, 32'h0, "rst_y");
      expect_val(O_Z, 32'h0, "rst_z");     expect_val(O_HI, 32'h0, "rst_hi");
      expect_val(O_LO, 32'h0, "rst_lo");   expect_val(O_PC, 32'h0, "rst_pc");
      expect_val(O_BUS, 32'h0, "idle_bus");

      // Register loads via MDR
      Mdatain = 32'h10; Read = 1'b1; MDRin = 1'b1;
      expect_val(O_MDRIN, 32'h10, "mdrin_mem");
      step();
      expect_val(O_MDR, 32'h10, "mdr_load");
      MDRout = 1'b1; R6in = 1'b1;
      expect_val(O_BUS, 32'h10, "bus_mdr");
      expect_val(O_MDRIN, 32'h10, "mdrin_bus");
      step();
      expect_val(O_R6, 32'h10, "r6_load");
      load_mdr(32'h2);
      MDRout = 1'b1; R7in = 1'b1;
      step();
      expect_val(O_R7, 32'h2, "r7_load");

      // Fetch
      PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
      step();
      expect_val(O_MAR, 32'h0, "fetch_mar");
      PCin = 1'b1; IncrementPC = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h2891_8000;
      step();
      expect_val(O_PC, 32'h1, "fetch_pc");
      expect_val(O_MDR, 32'h2891_8000, "fetch_mdr");
      MDRout = 1'b1; IRin = 1'b1;
      step();
      expect_val(O_IR, 32'h2891_8000, "fetch_ir");
      PCout = 1'b1;
      expect_val(O_BUS, 32'h1, "bus_pc");
      step();

      // DIV R6 / R7
      R6out = 1'b1; Yin = 1'b1;
      step();
      expect_val(O_Y, 32'h10, "div_y");
      R7out = 1'b1; ALUControl = 5'b00011; Zin = 1'b1;
      step();
      expect_val(O_Z, 32'h8, "div_z");
      ZLOout = 1'b1; LOin = 1'b1;
      step();
      expect_val(O_LO, 32'h8, "div_lo");
      ZHIout = 1'b1; HIin = 1'b1;
      step();
      expect_val(O_HI, 32'h0, "div_hi");

      // Priority when selects are not one-hot: MDRout beats R6out
      load_mdr(32'hA5A5_0001);
      MDRout = 1'b1; R6out = 1'b1; PCout = 1'b1;
      expect_val(O_BUS, 32'hA5A5_0001, "bus_prio");
      step();

      // Signed / edge division and multiply
      alu_run(32'hFFFF_FFF9, 32'h2, 5'd3, "div_neg");
      alu_run(32'hFFFF_FFF9, 32'h0, 5'd3, "div_zero");
      alu_run(32'h8000_0000, 32'hFFFF_FFFF, 5'd3, "div_ovf");
      alu_run(32'hFFFF_FFFF, 32'h2, 5'd2, "mul_neg");
      alu_run(32'h7FFF_FFFF, 32'h1, 5'd0, "add_wrap");
      alu_run(32'h0, 32'h1, 5'd1, "sub_wrap");
      alu_run(32'h1234_5678, 32'h0000_0020, 5'd9, "ror_32");
      alu_run(32'h1234_5678, 32'h5, 5'd31, "bad_op");

      // Randomized ops, biased towards divide edge cases
      for (int k = 0; k < 60; k++) begin
         logic [31:0] a, b;
         logic [4:0]  op;
         a  = $urandom();
         b  = $urandom();
         op = 5'($urandom_range(0, 15));
         if (op == 5'd3 && $urandom_range(0, 3) == 0) b = 32'h0;
         if (op == 5'd3 && $urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
         alu_run(a, b, op, $sformatf("rnd%0d_op%0d", k, op));
      end

      // Bounded drain of the scoreboard
      for (int w = 0; w < 10 && idq.size() > 0; w++) @(negedge Clock);
      @(posedge Clock);
      if (idq.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", idq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
